// File: rtl/contador_tempo.sv
// contador_tempo: 3-digit BCD m:ss countdown timer loaded by keypad digits, ticked at 1 Hz.
// Define CONTADOR_SEG7_EN to add 7-segment (a..g, active-high) decoded digit outputs.
module contador_tempo #(
    parameter int MAX_MIN = 9
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       enablen,
    output logic [3:0] secs_ones,
    output logic [3:0] secs_tens,
    output logic [3:0] mins,
    output logic       zero,
    output logic       done
`ifdef CONTADOR_SEG7_EN
    ,
    output logic [6:0] secs_ones_segs,
    output logic [6:0] secs_tens_segs,
    output logic [6:0] min_segs
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ARMED,
        S_RUNNING,
        S_PAUSED
    } state_t;

    localparam logic [3:0] MAX_L = 4'(MAX_MIN);

    state_t     state_q, state_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] mins_q, mins_d;
    logic       done_q, done_d;
    logic       loadn_q, loadn_d;

    logic strobe;
    logic entry;
    logic dec;
    logic nxt_zero;

    assign loadn_d  = loadn;
    assign strobe   = loadn_q & ~loadn;
    assign entry    = strobe & (D <= 4'd9) & (state_q != S_RUNNING);
    assign zero     = (ones_q == 4'd0) & (tens_q == 4'd0) & (mins_q == 4'd0);
    assign dec      = (state_q == S_RUNNING) & ~enablen & pgt_1Hz & ~zero;
    assign nxt_zero = (ones_d == 4'd0) & (tens_d == 4'd0) & (mins_d == 4'd0);

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            mins_q  <= 4'd0;
            done_q  <= 1'b0;
            loadn_q <= 1'b1;
        end else begin
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            mins_q  <= mins_d;
            done_q  <= done_d;
            loadn_q <= loadn_d;
        end
    end

    // Transitions look at the time as it will be after this cycle's entry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_EMPTY: begin
                if (entry) state_d = S_ARMED;
            end
            S_ARMED, S_PAUSED: begin
                if (nxt_zero)      state_d = S_EMPTY;
                else if (!enablen) state_d = S_RUNNING;
            end
            S_RUNNING: begin
                if (enablen)       state_d = S_PAUSED;
                else if (nxt_zero) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // A tick in RUNNING outranks a strobe; entry is already blocked there.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        mins_d = mins_q;
        done_d = 1'b0;
        if (dec) begin
            if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else begin
                ones_d = 4'd9;
                if (tens_q != 4'd0) begin
                    tens_d = tens_q - 4'd1;
                end else begin
                    tens_d = 4'd5;
                    mins_d = mins_q - 4'd1;
                end
            end
            done_d = (mins_q == 4'd0) & (tens_q == 4'd0)
                   & (ones_q == 4'd1);
        end else if (entry) begin
            mins_d = (tens_q > MAX_L) ? MAX_L : tens_q;
            tens_d = ones_q;
            ones_d = D;
        end
    end

    assign secs_ones = ones_q;
    assign secs_tens = tens_q;
    assign mins      = mins_q;
    assign done      = done_q;

`ifdef CONTADOR_SEG7_EN
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign secs_ones_segs = seg7(ones_q);
    assign secs_tens_segs = seg7(tens_q);
    assign min_segs       = (mins_q == 4'd0) ? 7'b0000000 : seg7(mins_q);
`endif

endmodule

// File: tb/tb_contador_tempo.sv
// Scoreboard bench for contador_tempo: time kept as a decimal number mmss-style,
// expected digits queued per cycle and checked by an independent monitor.
module tb_contador_tempo;

    localparam int MAXM = 5;
    localparam int M_EMPTY = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;

    logic       clk;
    logic       clear;
    logic [3:0] D;
    logic       loadn;
    logic       pgt_1Hz;
    logic       enablen;
    logic [3:0] secs_ones;
    logic [3:0] secs_tens;
    logic [3:0] mins;
    logic       zero;
    logic       done;
`ifdef CONTADOR_SEG7_EN
    logic [6:0] secs_ones_segs;
    logic [6:0] secs_tens_segs;
    logic [6:0] min_segs;
`endif

    contador_tempo #(.MAX_MIN(MAXM)) dut (
        .clk       (clk),
        .clear     (clear),
        .D         (D),
        .loadn     (loadn),
        .pgt_1Hz   (pgt_1Hz),
        .enablen   (enablen),
        .secs_ones (secs_ones),
        .secs_tens (secs_tens),
        .mins      (mins),
        .zero      (zero),
        .done      (done)
`ifdef CONTADOR_SEG7_EN
        ,
        .secs_ones_segs (secs_ones_segs),
        .secs_tens_segs (secs_tens_segs),
        .min_segs       (min_segs)
`endif
    );

    typedef struct {
        int   cyc;
        int   m;
        int   t;
        int   o;
        bit   z;
        bit   dn;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // behavioural model: time as decimal m*100 + tens*10 + ones
    int mn  = 0;
    int mst = M_EMPTY;
    bit mlq = 1'b1;
    bit mdn = 1'b0;

    logic [6:0] segtab [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101,
        7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input bit c, input bit ld, input int d,
                        input bit tk, input bit en);
        exp_t e;
        bit   stb;
        bit   acc;
        int   nn;
        int   tt;
        @(negedge clk);
        #1;
        clear   = c;
        loadn   = ld;
        D       = 4'(d);
        pgt_1Hz = tk;
        enablen = en;
        cyc++;
        if (c) begin
            mn = 0; mst = M_EMPTY; mlq = 1'b1; mdn = 1'b0;
        end else begin
            stb = mlq && !ld;
            mlq = ld;
            mdn = 1'b0;
            acc = stb && d <= 9 && mst != M_RUN;
            nn  = mn;
            if (acc) begin
                tt = (mn / 10) % 10;
                if (tt > MAXM) tt = MAXM;
                nn = tt * 100 + (mn % 10) * 10 + d;
            end
            case (mst)
                M_EMPTY: if (acc) mst = M_ARMED;
                M_ARMED, M_PAUSE: begin
                    if (nn == 0) mst = M_EMPTY;
                    else if (!en) mst = M_RUN;
                end
                default: begin
                    if (en) mst = M_PAUSE;
                    else if (mn == 0) mst = M_EMPTY;
                    else if (tk) begin
                        nn = (mn % 100 == 0) ? mn - 41 : mn - 1;
                        if (nn == 0) begin
                            mst = M_EMPTY;
                            mdn = 1'b1;
                        end
                    end
                end
            endcase
            mn = nn;
        end
        e.cyc = cyc;
        e.m   = mn / 100;
        e.t   = (mn / 10) % 10;
        e.o   = mn % 10;
        e.z   = (mn == 0);
        e.dn  = mdn;
        q.push_back(e);
    endtask

    task automatic idle(input int n, input bit tk, input bit en);
        for (int i = 0; i < n; i++) step(0, 1, 0, tk, en);
    endtask

    task automatic put_digit(input int d, input bit en);
        for (int i = 0; i < 3; i++) step(0, 0, d, 0, en);
        step(0, 1, d, 0, en);
        step(0, 1, d, 0, en);
    endtask

    // monitor: one expected entry per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (mins !== 4'(e.m) || secs_tens !== 4'(e.t)
                    || secs_ones !== 4'(e.o) || zero !== e.z
                    || done !== e.dn) begin
                    miscompares++;
                    $display("FAIL cyc%0d digits got %h:%h%h z%b d%b want %0d:%0d%0d z%b d%b",
                        e.cyc, mins, secs_tens, secs_ones, zero, done,
                        e.m, e.t, e.o, e.z, e.dn);
                end
`ifdef CONTADOR_SEG7_EN
                vectors++;
                if (secs_ones_segs !== segtab[e.o]
                    || secs_tens_segs !== segtab[e.t]
                    || min_segs !== ((e.m == 0) ? 7'b0 : segtab[e.m])) begin
                    miscompares++;
                    $display("FAIL cyc%0d segs got %b %b %b for %0d:%0d%0d",
                        e.cyc, min_segs, secs_tens_segs, secs_ones_segs,
                        e.m, e.t, e.o);
                end
`endif
            end
        end
    end

    initial begin
        clear = 1'b1; loadn = 1'b1; D = 4'd0; pgt_1Hz = 1'b0; enablen = 1'b1;
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        idle(2, 1, 1);
        // entry 1,2,3 then run and clear mid-count
        put_digit(1, 1);
        put_digit(2, 1);
        put_digit(3, 1);
        idle(2, 0, 0);
        idle(3, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        idle(3, 1, 0);
        // held strobe, illegal digit
        for (int i = 0; i < 10; i++) step(0, 0, 4, 0, 1);
        idle(2, 0, 1);
        put_digit(12, 1);
        // clamp 9,9,9 -> 5:99
        step(1, 1, 0, 0, 1);
        put_digit(9, 1);
        put_digit(9, 1);
        put_digit(9, 1);
        // 1:00 countdown through zero and beyond
        step(1, 1, 0, 0, 1);
        put_digit(1, 1);
        put_digit(0, 1);
        put_digit(0, 1);
        idle(2, 0, 0);
        for (int i = 0; i < 60; i++) begin
            step(0, 1, 0, 1, 0);
            step(0, 1, 0, 0, 0);
        end
        idle(5, 1, 0);
        // pause with tick, paused entry, strobe with tick while running
        step(1, 1, 0, 0, 1);
        put_digit(1, 1);
        put_digit(0, 1);
        idle(2, 0, 0);
        step(0, 1, 0, 1, 1);
        idle(2, 0, 1);
        put_digit(5, 1);
        idle(2, 0, 0);
        step(0, 0, 7, 1, 0);
        idle(3, 0, 0);
        // randomized rounds
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 25; i++)
                step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 11), $urandom_range(0, 3) == 0,
                     $urandom_range(0, 5) != 0);
            for (int i = 0; i < 150; i++)
                step($urandom_range(0, 399) == 0, $urandom_range(0, 15) != 0,
                     $urandom_range(0, 11), $urandom_range(0, 1) == 0,
                     $urandom_range(0, 9) == 0);
        end
        repeat (3) @(posedge clk);
        #5;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
            vectors, miscompares);
        $finish;
    end

endmodule
